// File: rtl/mt_header_loader.sv
// Polls a BRAM header-ready flag, then copies NUM_CH channel base-address words
// out of BRAM into registers, optionally clearing the flag once the copy is done.
module mt_header_loader #(
   parameter int                NUM_CH      = 8,
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] READY_ADDR  = ADDR_W'(32'h4580_0020),
   parameter logic [DATA_W-1:0] READY_VALUE = DATA_W'(1),
   parameter logic [ADDR_W-1:0] START_ADDR  = ADDR_W'(32'h4580_0000),
   parameter int                OFFSET      = 4,
   parameter int                RD_LATENCY  = 2,
   parameter bit                CLEAR_FLAG  = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     ram_clk,
   output logic                     ram_rst,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic                     ram_en,
   output logic [DATA_W/8-1:0]      ram_we,
   output logic [DATA_W-1:0]        ram_wd_data,
   input  logic [DATA_W-1:0]        ram_rd_data,
   input  logic                     rearm,
   output logic [NUM_CH*DATA_W-1:0] base_addr_flat,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic                     all_ready,
   output logic                     busy
);

   localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
   localparam logic [2:0]       LAT_LAST = 3'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      POLL,
      LOAD,
      CLEAR,
      DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         ram_addr_q, ram_addr_d;
   logic [2:0]                lat_cnt_q, lat_cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [NUM_CH*DATA_W-1:0]  base_q, base_d;
   logic [NUM_CH-1:0]         ch_ready_q, ch_ready_d;
   logic                      all_ready_q, all_ready_d;
   logic                      sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= POLL;
         ram_addr_q  <= READY_ADDR;
         lat_cnt_q   <= 3'd0;
         idx_q       <= '0;
         base_q      <= '0;
         ch_ready_q  <= '0;
         all_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_addr_q  <= ram_addr_d;
         lat_cnt_q   <= lat_cnt_d;
         idx_q       <= idx_d;
         base_q      <= base_d;
         ch_ready_q  <= ch_ready_d;
         all_ready_q <= all_ready_d;
      end
   end

   // The address edge restarts lat_cnt; read data is taken on the RD_LATENCY-th edge after it.
   always_comb begin
      state_d     = state_q;
      ram_addr_d  = ram_addr_q;
      lat_cnt_d   = lat_cnt_q;
      idx_d       = idx_q;
      base_d      = base_q;
      ch_ready_d  = ch_ready_q;
      all_ready_d = &ch_ready_q;
      sample      = (lat_cnt_q == LAT_LAST);

      case (state_q)
         POLL: begin
            if (sample) begin
               lat_cnt_d = 3'd0;
               if (ram_rd_data == READY_VALUE) begin
                  state_d    = LOAD;
                  idx_d      = '0;
                  ram_addr_d = START_ADDR;
               end else begin
                  ram_addr_d = READY_ADDR;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         LOAD: begin
            if (sample) begin
               lat_cnt_d                         = 3'd0;
               base_d[idx_q*DATA_W +: DATA_W]    = ram_rd_data;
               ch_ready_d[idx_q]                 = 1'b1;
               if (idx_q != LAST_IDX) begin
                  idx_d      = idx_q + 1'b1;
                  ram_addr_d = ram_addr_q + ADDR_W'(OFFSET);
               end else if (CLEAR_FLAG) begin
                  state_d    = CLEAR;
                  ram_addr_d = READY_ADDR;
               end else begin
                  state_d = DONE;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         CLEAR: begin
            state_d = DONE;
         end
         DONE: begin
            // Old base words stay visible until the next load overwrites each slot.
            if (rearm) begin
               state_d     = POLL;
               ram_addr_d  = READY_ADDR;
               lat_cnt_d   = 3'd0;
               idx_d       = '0;
               ch_ready_d  = '0;
               all_ready_d = 1'b0;
            end
         end
         default: begin
            state_d = POLL;
         end
      endcase
   end

   assign ram_clk        = clk;
   assign ram_rst        = 1'b0;
   assign ram_en         = 1'b1;
   assign ram_addr       = ram_addr_q;
   assign ram_we         = (state_q == CLEAR) ? '1 : '0;
   assign ram_wd_data    = '0;
   assign base_addr_flat = base_q;
   assign ch_ready       = ch_ready_q;
   assign all_ready      = all_ready_q;
   assign busy           = (state_q != DONE);

endmodule

// File: tb/tb_mt_header_loader.sv
// Bench for mt_header_loader: a 4-channel loader with flag clearing and a
// 1-channel, single-cycle-latency loader without it, each on a small BRAM model.
module tb_mt_header_loader;

   localparam logic [31:0]  READY_ADDR = 32'h4580_0020;
   localparam logic [31:0]  START_ADDR = 32'h4580_0000;
   localparam logic [127:0] FLAT_A = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
   localparam logic [127:0] FLAT_B = {32'hB3B3_1003, 32'hB2B2_1002, 32'hB1B1_1001, 32'hB0B0_1000};
   localparam logic [127:0] FLAT_C = {32'hC3C3_2003, 32'hC2C2_2002, 32'hC1C1_2001, 32'hC0C0_2000};

   typedef struct {
      logic        rearm;
      logic [31:0] addr;
      logic [3:0]  ch;
      logic [3:0]  we;
      logic        all;
      logic        busy;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] word;
   } sb_t;

   int   n_cmp  = 0;
   int   n_fail = 0;
   int   writes_a = 0;
   int   writes_b = 0;
   sb_t  sb_q[$];
   vec_t tbl[11];

   logic clk = 1'b0;
   logic rst_n, rst_b_n;

   logic         ram_clk_a, ram_rst_a, ram_en_a, rearm_a, all_ready_a, busy_a;
   logic [31:0]  ram_addr_a, ram_wd_data_a, ram_rd_data_a;
   logic [3:0]   ram_we_a, ch_ready_a;
   logic [127:0] base_a;

   logic         ram_clk_b, ram_rst_b, ram_en_b, rearm_b, all_ready_b, busy_b;
   logic [31:0]  ram_addr_b, ram_wd_data_b, ram_rd_data_b, base_b;
   logic [3:0]   ram_we_b;
   logic [0:0]   ch_ready_b;

   logic [31:0] flag_a, addr_pipe_a, flag_b, word_b;
   logic [31:0] words_a [4];
   logic [3:0]  prev_ch_a = 4'd0;

   always #5 clk = ~clk;

   mt_header_loader #(.NUM_CH(4), .RD_LATENCY(2), .CLEAR_FLAG(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .ram_clk(ram_clk_a), .ram_rst(ram_rst_a),
      .ram_addr(ram_addr_a), .ram_en(ram_en_a), .ram_we(ram_we_a),
      .ram_wd_data(ram_wd_data_a), .ram_rd_data(ram_rd_data_a), .rearm(rearm_a),
      .base_addr_flat(base_a), .ch_ready(ch_ready_a), .all_ready(all_ready_a),
      .busy(busy_a)
   );

   mt_header_loader #(.NUM_CH(1), .RD_LATENCY(1), .CLEAR_FLAG(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .ram_clk(ram_clk_b), .ram_rst(ram_rst_b),
      .ram_addr(ram_addr_b), .ram_en(ram_en_b), .ram_we(ram_we_b),
      .ram_wd_data(ram_wd_data_b), .ram_rd_data(ram_rd_data_b), .rearm(rearm_b),
      .base_addr_flat(base_b), .ch_ready(ch_ready_b), .all_ready(all_ready_b),
      .busy(busy_b)
   );

   // Two-edge BRAM for dut_a: the address is registered once inside the RAM.
   always @(posedge clk) addr_pipe_a <= ram_addr_a;
   assign ram_rd_data_a = (addr_pipe_a === READY_ADDR) ? flag_a :
                          (addr_pipe_a[31:4] === 28'h4580000) ? words_a[addr_pipe_a[3:2]] :
                          32'hDEAD_BEEF;
   assign ram_rd_data_b = (ram_addr_b === READY_ADDR) ? flag_b :
                          (ram_addr_b === START_ADDR) ? word_b : 32'hDEAD_BEEF;

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic r);
      rearm_a = r;
   endtask

   task automatic program_load(input logic [127:0] flat);
      for (int i = 0; i < 4; i++) begin
         words_a[i] = flat[i*32 +: 32];
         sb_q.push_back('{idx: i, word: flat[i*32 +: 32]});
      end
   endtask

   // Each newly set ch_ready bit must be the next slot in the queue, carrying its word.
   always @(negedge clk) begin
      if (ch_ready_a == 4'd0) begin
         prev_ch_a = 4'd0;
      end else if (ch_ready_a != prev_ch_a) begin
         if (sb_q.size() == 0) begin
            check_output("sb_unexpected_fill", ch_ready_a, prev_ch_a);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check_output("sb_fill_bit", ch_ready_a & ~prev_ch_a, 128'(4'b0001 << e.idx));
            check_output("sb_fill_word", base_a[e.idx*32 +: 32], e.word);
         end
         prev_ch_a = ch_ready_a;
      end
   end

   always @(negedge clk) begin
      if (ram_we_a != 4'd0) begin
         writes_a++;
         check_output("wr_addr", ram_addr_a, READY_ADDR);
         check_output("wr_we", ram_we_a, 4'hF);
         check_output("wr_data", ram_wd_data_a, 32'd0);
      end
      if (ram_we_b != 4'd0) writes_b++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      // Cycle-by-cycle view of one load, row k taken after the k-th edge past LOAD entry.
      tbl[0]  = '{1'b0, 32'h4580_0000, 4'b0000, 4'h0, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 32'h4580_0000, 4'b0000, 4'h0, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 32'h4580_0004, 4'b0001, 4'h0, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 32'h4580_0004, 4'b0001, 4'h0, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 32'h4580_0008, 4'b0011, 4'h0, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 32'h4580_0008, 4'b0011, 4'h0, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 32'h4580_000C, 4'b0111, 4'h0, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 32'h4580_000C, 4'b0111, 4'h0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 32'h4580_0020, 4'b1111, 4'hF, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 32'h4580_0020, 4'b1111, 4'h0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 32'h4580_0020, 4'b1111, 4'h0, 1'b1, 1'b0};

      rst_n = 1'b0; rst_b_n = 1'b0;
      rearm_a = 1'b0; rearm_b = 1'b0;
      flag_a = 32'd0; flag_b = 32'd0; word_b = 32'd0;
      for (int i = 0; i < 4; i++) words_a[i] = 32'd0;

      @(negedge clk);
      check_output("rst_addr", ram_addr_a, READY_ADDR);
      check_output("rst_we", ram_we_a, 4'h0);
      check_output("rst_ch", ch_ready_a, 4'h0);
      check_output("rst_all", all_ready_a, 1'b0);
      check_output("rst_base", base_a, 128'd0);
      check_output("rst_busy", busy_a, 1'b1);
      check_output("ram_en", ram_en_a, 1'b1);
      check_output("ram_rst", ram_rst_a, 1'b0);
      check_output("ram_clk", ram_clk_a, clk);

      $display("[TB] first load, flag already set at release");
      flag_a = 32'd1;
      program_load(FLAT_A);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("first_poll_pending", ram_addr_a, READY_ADDR);
      @(negedge clk);
      for (int k = 0; k < 11; k++) begin
         if (k > 0) @(negedge clk);
         check_output($sformatf("row%0d_addr", k), ram_addr_a, tbl[k].addr);
         check_output($sformatf("row%0d_ch", k), ch_ready_a, tbl[k].ch);
         check_output($sformatf("row%0d_we", k), ram_we_a, tbl[k].we);
         check_output($sformatf("row%0d_all", k), all_ready_a, tbl[k].all);
         check_output($sformatf("row%0d_busy", k), busy_a, tbl[k].busy);
         apply_stimulus(tbl[k].rearm);
      end
      check_output("load_a_base", base_a, FLAT_A);
      check_output("load_a_writes", writes_a, 1);

      $display("[TB] rearm from DONE, flag held low then garbage");
      flag_a = 32'd0;
      program_load(FLAT_B);
      apply_stimulus(1'b1);
      @(negedge clk);
      apply_stimulus(1'b0);
      check_output("rearm_ch", ch_ready_a, 4'h0);
      check_output("rearm_all", all_ready_a, 1'b0);
      check_output("rearm_busy", busy_a, 1'b1);
      check_output("rearm_addr", ram_addr_a, READY_ADDR);
      check_output("rearm_old_base", base_a, FLAT_A);
      for (int c = 0; c < 10; c++) begin
         flag_a = (c < 5) ? 32'd0 : 32'hFFFF_FFFE;
         @(negedge clk);
         check_output($sformatf("poll%0d_addr", c), ram_addr_a, READY_ADDR);
         check_output($sformatf("poll%0d_ch", c), ch_ready_a, 4'h0);
      end
      flag_a = 32'd1;
      n = 0;
      while (ram_addr_a !== START_ADDR && n < 10) begin @(negedge clk); n++; end
      check_output("poll_to_load", ram_addr_a, START_ADDR);
      n = 0;
      while (all_ready_a !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      check_output("load_b_all", all_ready_a, 1'b1);
      check_output("load_b_base", base_a, FLAT_B);
      check_output("load_b_writes", writes_a, 2);

      $display("[TB] reset in the middle of a load");
      flag_a = 32'd1;
      program_load(FLAT_C);
      apply_stimulus(1'b1);
      @(negedge clk);
      apply_stimulus(1'b0);
      n = 0;
      while (ch_ready_a !== 4'b0011 && n < 30) begin @(negedge clk); n++; end
      check_output("midload_ch", ch_ready_a, 4'b0011);
      #1 rst_n = 1'b0;
      #1;
      check_output("async_addr", ram_addr_a, READY_ADDR);
      check_output("async_ch", ch_ready_a, 4'h0);
      check_output("async_all", all_ready_a, 1'b0);
      check_output("async_base", base_a, 128'd0);
      check_output("async_we", ram_we_a, 4'h0);
      sb_q.delete();
      flag_a = 32'd0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_output($sformatf("repoll%0d_addr", c), ram_addr_a, READY_ADDR);
         check_output($sformatf("repoll%0d_busy", c), busy_a, 1'b1);
      end
      flag_a = 32'd1;
      program_load(FLAT_C);
      n = 0;
      while (all_ready_a !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      check_output("load_c_all", all_ready_a, 1'b1);
      check_output("load_c_base", base_a, FLAT_C);
      check_output("load_c_writes", writes_a, 3);
      check_output("sb_drained", sb_q.size(), 0);

      $display("[TB] single channel, one-edge latency, no flag clear");
      flag_b = 32'd1;
      word_b = 32'hD00D_1234;
      rst_b_n = 1'b1;
      @(negedge clk);
      check_output("b_load_addr", ram_addr_b, START_ADDR);
      check_output("b_load_ch", ch_ready_b, 1'b0);
      check_output("b_load_busy", busy_b, 1'b1);
      @(negedge clk);
      check_output("b_done_ch", ch_ready_b, 1'b1);
      check_output("b_done_all", all_ready_b, 1'b0);
      check_output("b_done_busy", busy_b, 1'b0);
      check_output("b_done_base", base_b, 32'hD00D_1234);
      @(negedge clk);
      check_output("b_all", all_ready_b, 1'b1);
      check_output("b_addr_hold", ram_addr_b, START_ADDR);
      repeat (3) @(negedge clk);
      check_output("b_still_done", busy_b, 1'b0);
      check_output("b_no_writes", writes_b, 0);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mt_header_loader.md
MT_HEADER_LOADER -- requirements
Module: mt_header_loader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_CH, 8, number of channel base-address words (1..16).
- ADDR_W, 32, BRAM byte-address width.
- DATA_W, 32, BRAM data width.
- READY_ADDR, 32'h4580_0020, header-ready flag word address.
- READY_VALUE, 1, flag value meaning "header valid".
- START_ADDR, 32'h4580_0000, channel 0 base-address word address.
- OFFSET, 4, byte stride between channel words.
- RD_LATENCY, 2, edges from ram_addr update to valid ram_rd_data (1..7).
- CLEAR_FLAG, 1, when 1, write 0 to READY_ADDR after the load completes.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset: asynchronous, active-low.
- ram_clk, out, 1, equals clk.
- ram_rst, out, 1, constant 0.
- ram_addr, out, ADDR_W, registered BRAM address.
- ram_en, out, 1, constant 1.
- ram_we, out, DATA_W/8, byte write enables.
- ram_wd_data, out, DATA_W, write data, constant 0.
- ram_rd_data, in, DATA_W, BRAM read data.
- rearm, in, 1, single-cycle request to reload the header.
- base_addr_flat, out, NUM_CH*DATA_W, channel i word at bits [i*DATA_W +: DATA_W].
- ch_ready, out, NUM_CH, bit i set once channel i word is captured.
- all_ready, out, 1, all channels captured.
- busy, out, 1, high in POLL/LOAD/CLEAR.

Function
REQ-003 The FSM SHALL have states POLL, LOAD, CLEAR, DONE, and SHALL reset into POLL.
REQ-004 Every read SHALL proceed as follows: ram_addr is updated on edge E0; latency counter lat_cnt is cleared; ram_rd_data is sampled on edge E0+RD_LATENCY; no other address is presented in between.
REQ-005 POLL: ram_addr SHALL be READY_ADDR. On sample, data==READY_VALUE SHALL enter LOAD with idx=0 and ram_addr=START_ADDR on the same edge. Otherwise a new poll read SHALL start on the same edge, giving a poll period of RD_LATENCY cycles.
REQ-006 LOAD: on each sample, the word SHALL be written into slot idx and ch_ready[idx] set on that edge. If idx<NUM_CH-1, idx SHALL increment and ram_addr SHALL become START_ADDR+(idx+1)*OFFSET. Otherwise the FSM SHALL go to CLEAR if CLEAR_FLAG=1, else to DONE.
REQ-007 Address arithmetic SHALL be modulo 2^ADDR_W; idx SHALL be $clog2(NUM_CH) bits wide, minimum 1.
REQ-008 CLEAR SHALL last exactly one cycle: ram_addr=READY_ADDR, ram_we all ones, ram_wd_data=0. It SHALL then go to DONE.
REQ-009 ram_we SHALL be 0 in every other state.
REQ-010 DONE: all_ready=1, busy=0, ram_addr holds its value.
REQ-011 rearm sampled high in DONE SHALL do all of the following on that edge: clear ch_ready and all_ready, enter POLL, start a poll read. base_addr_flat SHALL retain its old values until each slot is overwritten.
REQ-012 rearm in POLL/LOAD/CLEAR SHALL be ignored; it SHALL NOT be queued.
REQ-013 ch_ready SHALL be monotonic within one load and SHALL fill strictly in order 0..NUM_CH-1. all_ready SHALL equal &ch_ready registered; it rises on the edge after ch_ready[NUM_CH-1] is set, or on the edge of entering DONE, whichever is later.
REQ-014 A flag value other than READY_VALUE, including X-free garbage, SHALL keep the block in POLL indefinitely, with no timeout.

Reset
REQ-015 With rst_n low, regardless of prior state, mid-load included, the following SHALL hold: state=POLL, ram_addr=READY_ADDR, lat_cnt=0, idx=0, ram_we=0, base_addr_flat=0, ch_ready=0, all_ready=0, busy=1 after release.
REQ-016 The first poll read after rst_n rises SHALL sample on the RD_LATENCY-th edge after release.

Verification (NUM_CH=4, RD_LATENCY=2, default addresses)
REQ-017 Scenario: flag word=0 for 10 cycles, then 1 -> ram_addr stays 4580_0020; LOAD entered on the first sample reading 1; reads then go to 4580_0000, _0004, _0008, _000C at 2-cycle spacing.
REQ-018 Scenario: channel words A0,A1,A2,A3 -> base_addr_flat={A3,A2,A1,A0}; ch_ready steps 0001, 0011, 0111, 1111; all_ready=1 eight cycles after LOAD entry plus the CLEAR cycle.
REQ-019 Scenario: CLEAR_FLAG=1 -> exactly one write cycle with addr 4580_0020, we=1111, data 0; CLEAR_FLAG=0 -> no write ever occurs.
REQ-020 Scenario: rearm pulse during LOAD -> ignored, load completes normally; rearm in DONE -> ch_ready=0 and POLL on the next cycle, with old base values still visible.
REQ-021 Scenario: rst_n asserted after ch_ready=0011 -> all outputs at reset values immediately (asynchronous); after release, polling restarts at 4580_0020.
REQ-022 Scenario: NUM_CH=1, RD_LATENCY=1 -> single load from START_ADDR; ch_ready=1 and all_ready=1 with no index overflow.
